// File: rtl/rle_bit_encoder_pkg.sv
// Shared definitions for the run-length bit encoder: default sizes,
// FSM state encoding and record layout {bit, len}.
package rle_bit_encoder_pkg;

  localparam int CNT_W_DEF      = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int REC_W_DEF      = CNT_W_DEF + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int rec_w(input int cnt_w);
    return cnt_w + 1;
  endfunction

endpackage

// File: rtl/rle_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word is driven
// combinationally from storage and reads zero while empty.
module rle_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic          do_push;
  logic          do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = empty ? '0 : mem[rd_ptr];
  assign level = level_q;

endmodule

// File: rtl/rle_bit_encoder.sv
// Run-length encoder for a sample-enabled serial bit stream; closed runs
// are queued as {bit, len} records and drained over valid/ready.
module rle_bit_encoder
  import rle_bit_encoder_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_bit,
  input  logic                          in_en,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_bit,
  output logic [CNT_W-1:0]              out_len,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output state_t                        state_dbg
);

  // Handshake: a record transfers on every rising edge where out_valid and
  // out_ready are both high; out_* stay put while valid waits for ready.

  localparam int              REC_W  = rec_w(CNT_W);
  localparam logic [CNT_W-1:0] MAXLEN = '1;

  state_t           state_q, state_d;
  logic             cur_bit_q, cur_bit_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic             overflow_q;

  logic             emit;
  logic [REC_W-1:0] emit_rec;
  logic [REC_W-1:0] head_rec;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cur_bit_q <= 1'b0;
      run_len_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_bit_q <= cur_bit_d;
      run_len_q <= run_len_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_bit_d = cur_bit_q;
    run_len_d = run_len_q;
    emit      = 1'b0;
    emit_rec  = {cur_bit_q, run_len_q};
    case (state_q)
      ST_IDLE: begin
        if (in_en) begin
          cur_bit_d = in_bit;
          run_len_d = CNT_W'(1);
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush) begin
          // Flush wins over the sample's own run logic, so one emit at most.
          emit = 1'b1;
          if (in_en) begin
            cur_bit_d = in_bit;
            run_len_d = CNT_W'(1);
          end else begin
            run_len_d = '0;
            state_d   = ST_IDLE;
          end
        end else if (in_en) begin
          if (in_bit != cur_bit_q) begin
            emit      = 1'b1;
            cur_bit_d = in_bit;
            run_len_d = CNT_W'(1);
          end else if (run_len_q == MAXLEN) begin
            emit      = 1'b1;
            run_len_d = CNT_W'(1);
          end else begin
            run_len_d = run_len_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop = out_valid && out_ready;

  rle_fifo #(
    .W     (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (emit),
    .din   (emit_rec),
    .pop   (pop),
    .dout  (head_rec),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky until reset: records lost when the buffer was full and not draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (emit && fifo_full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  assign out_valid          = !fifo_empty;
  assign {out_bit, out_len} = head_rec;
  assign overflow           = overflow_q;
  assign state_dbg          = state_q;

endmodule

// File: tb/tb_rle_bit_encoder.sv
// Directed bench for rle_bit_encoder with CNT_W=4 and a 4-deep buffer.
module tb_rle_bit_encoder;
  import rle_bit_encoder_pkg::*;

  localparam int CW    = 4;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_bit = 1'b0;
  logic          in_en = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic          out_bit;
  logic [CW-1:0] out_len;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  state_t        state_dbg;

  logic [CW:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic          en, b, fl, rdy;
    logic          emit, ebit;
    logic [CW-1:0] elen;
    logic [LW-1:0] elvl;
    logic          eovf;
    state_t        est;
  } vec_t;
  vec_t vecs[$];

  rle_bit_encoder #(.CNT_W(CW), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_bit     (in_bit),
    .in_en      (in_en),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bit    (out_bit),
    .out_len    (out_len),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic b);
    in_en  = 1'b1;
    in_bit = b;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_en = 1'b0; in_bit = 1'b0; flush = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic add(input logic en, b, fl, rdy, emit, ebit, input logic [CW-1:0] elen,
                     input logic [LW-1:0] elvl, input logic eovf, input state_t est);
    vec_t v;
    v.en = en; v.b = b; v.fl = fl; v.rdy = rdy; v.emit = emit; v.ebit = ebit;
    v.elen = elen; v.elvl = elvl; v.eovf = eovf; v.est = est;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      in_en = vecs[i].en; in_bit = vecs[i].b; flush = vecs[i].fl; out_ready = vecs[i].rdy;
      if (vecs[i].emit) exp_q.push_back({vecs[i].ebit, vecs[i].elen});
      step();
      chk($sformatf("%s[%0d].level", tag, i), 32'(fifo_level), 32'(vecs[i].elvl));
      chk($sformatf("%s[%0d].overflow", tag, i), 32'(overflow), 32'(vecs[i].eovf));
      chk($sformatf("%s[%0d].state", tag, i), 32'(state_dbg), 32'(vecs[i].est));
    end
    vecs.delete();
    in_en = 1'b0; flush = 1'b0;
  endtask

  // Scoreboard: every accepted record must match the oldest expected one.
  always @(negedge clk) begin : sb
    logic [CW:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got %0h expected none", {out_bit, out_len});
      end else begin
        e = exp_q.pop_front();
        chk("sb_record", 32'({out_bit, out_len}), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2;
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.level", 32'(fifo_level), 0);
    chk("rst.overflow", 32'(overflow), 0);
    chk("rst.out_rec", 32'({out_bit, out_len}), 0);
    chk("rst.state", 32'(state_dbg), 32'(ST_IDLE));
    do_reset();

    // Normal runs 1,1,1,0,0 + flush, then flush alone in IDLE.
    add(1,1,0,1, 0,0,0, 0,0, ST_RUN);
    add(1,1,0,1, 0,0,0, 0,0, ST_RUN);
    add(1,1,0,1, 0,0,0, 0,0, ST_RUN);
    add(1,0,0,1, 1,1,3, 1,0, ST_RUN);
    add(1,0,0,1, 0,0,0, 0,0, ST_RUN);
    add(0,0,1,1, 1,0,2, 1,0, ST_IDLE);
    add(0,0,0,1, 0,0,0, 0,0, ST_IDLE);
    add(0,0,1,1, 0,0,0, 0,0, ST_IDLE);
    // Flush together with a sample opens a fresh run.
    add(1,0,0,1, 0,0,0, 0,0, ST_RUN);
    add(1,0,0,1, 0,0,0, 0,0, ST_RUN);
    add(1,0,0,1, 0,0,0, 0,0, ST_RUN);
    add(1,1,1,1, 1,0,3, 1,0, ST_RUN);
    add(0,0,0,1, 0,0,0, 0,0, ST_RUN);
    add(0,0,1,1, 1,1,1, 1,0, ST_IDLE);
    add(0,0,0,1, 0,0,0, 0,0, ST_IDLE);
    run_vecs("normal");

    // Backpressure: six emits into a 4-deep buffer, then drain.
    do_reset();
    add(1,0,0,0, 0,0,0, 0,0, ST_RUN);
    add(1,1,0,0, 1,0,1, 1,0, ST_RUN);
    add(1,0,0,0, 1,1,1, 2,0, ST_RUN);
    add(1,1,0,0, 1,0,1, 3,0, ST_RUN);
    add(1,0,0,0, 1,1,1, 4,0, ST_RUN);
    add(1,1,0,0, 0,0,0, 4,1, ST_RUN);
    add(1,0,0,0, 0,0,0, 4,1, ST_RUN);
    add(0,0,0,1, 0,0,0, 3,1, ST_RUN);
    add(0,0,0,1, 0,0,0, 2,1, ST_RUN);
    add(0,0,0,1, 0,0,0, 1,1, ST_RUN);
    add(0,0,0,1, 0,0,0, 0,1, ST_RUN);
    add(0,0,0,1, 0,0,0, 0,1, ST_RUN);
    run_vecs("bp");

    // Saturation split at MAXLEN=15.
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back({1'b1, 4'd15});
    for (int i = 1; i <= 15; i++) sample(1'b1);
    chk("sat.valid_before", 32'(out_valid), 0);
    sample(1'b1);
    chk("sat.valid16", 32'(out_valid), 1);
    chk("sat.rec16", 32'({out_bit, out_len}), 32'({1'b1, 4'd15}));
    sample(1'b1);
    in_en = 1'b0;
    flush = 1'b1;
    exp_q.push_back({1'b1, 4'd2});
    step();
    flush = 1'b0;
    chk("sat.rec_flush", 32'({out_bit, out_len}), 32'({1'b1, 4'd2}));
    step();
    chk("sat.level_end", 32'(fifo_level), 0);

    // Full buffer with a push and a pop on the same edge.
    do_reset();
    sample(1'b0);
    exp_q.push_back({1'b0, 4'd1}); sample(1'b1);
    exp_q.push_back({1'b1, 4'd1}); sample(1'b0);
    exp_q.push_back({1'b0, 4'd1}); sample(1'b1);
    exp_q.push_back({1'b1, 4'd1}); sample(1'b0);
    sample(1'b0);
    chk("full.level", 32'(fifo_level), 4);
    out_ready = 1'b1;
    exp_q.push_back({1'b0, 4'd2});
    sample(1'b1);
    in_en = 1'b0;
    chk("full.level_pp", 32'(fifo_level), 4);
    chk("full.overflow", 32'(overflow), 0);
    repeat (6) step();
    chk("full.level_drained", 32'(fifo_level), 0);

    // Asynchronous reset mid-cycle discards queue and partial run.
    do_reset();
    sample(1'b1); sample(1'b0); sample(1'b1);
    chk("ar.level_pre", 32'(fifo_level), 2);
    repeat (4) sample(1'b1);
    in_en = 1'b0;
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("ar.out_valid", 32'(out_valid), 0);
    chk("ar.level", 32'(fifo_level), 0);
    chk("ar.overflow", 32'(overflow), 0);
    chk("ar.out_rec", 32'({out_bit, out_len}), 0);
    chk("ar.state", 32'(state_dbg), 32'(ST_IDLE));
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) step();
    chk("ar.no_record", 32'(out_valid), 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("ar.flush_idle", 32'(fifo_level), 0);
    step();

    chk("sb.leftover", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rle_bit_encoder.md
Name: rle_bit_encoder

Overview:
- Downstream consumer of the single-bit registered sampler stage.
- Takes the registered serial bit, qualified by a sample enable, and run-length encodes it into {bit value, run length} records.
- Records are buffered in a small first-word-fall-through FIFO and drained over a valid/ready handshake.
- Feeds the counter/display logic of the lab datapath.

Parameters:
- CNT_W, 8, run-length field width; max run MAXLEN = 2^CNT_W - 1.
- FIFO_DEPTH, 4, record buffer depth; power of 2, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_bit  input  1  registered sample from the upstream sampler stage.
- in_en  input  1  in_bit is a valid sample this cycle.
- flush  input  1  close the current run and emit it.
- out_valid  output  1  FIFO head record available.
- out_ready  input  1  consumer accepts the head record this cycle.
- out_bit  output  1  bit value of the head record.
- out_len  output  CNT_W  run length of the head record (1..MAXLEN).
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of stored records.
- overflow  output  1  sticky: at least one record was dropped.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (asynchronous, effective immediately):
  - State goes to IDLE; cur_bit=0, run_len=0.
  - FIFO is emptied: out_valid=0, fifo_level=0, overflow=0.
  - out_bit and out_len read 0.
  - A partial run is discarded, never emitted.
- FSM states: IDLE (no open run), RUN (open run in cur_bit/run_len).
- IDLE:
  - in_en: cur_bit<=in_bit, run_len<=1, go to RUN.
  - flush alone: no effect.
- RUN with in_en and no flush:
  - in_bit==cur_bit and run_len<MAXLEN: run_len++.
  - in_bit!=cur_bit: emit {cur_bit, run_len}; cur_bit<=in_bit, run_len<=1.
  - in_bit==cur_bit and run_len==MAXLEN: emit {cur_bit, MAXLEN}; run_len<=1, same bit (saturation split).
- RUN with flush:
  - Emit {cur_bit, run_len}.
  - If in_en is also high: the sample opens a new run with len 1 and the state stays RUN; otherwise go to IDLE.
  - Flush takes priority, so at most one emit per cycle.
- Emit and pop rules:
  - An emit is a FIFO push at the same clock edge.
  - A pop occurs when out_valid && out_ready.
  - Push when full with no pop in the same cycle: the record is dropped and overflow is set. overflow is cleared only by reset.
  - Push and pop in the same cycle when full: both succeed; level stays at FIFO_DEPTH; no overflow.
  - Push and pop in the same cycle when empty: the push succeeds; level becomes 1 (no bypass).
- Latency:
  - The record closed at edge N is visible on out_* with out_valid=1 after edge N, i.e. the FIFO is first-word-fall-through.
  - Records emerge in emit order.
- out_* hold stable while out_valid && !out_ready.
- Pointers wrap modulo FIFO_DEPTH; the level counter distinguishes full from empty.
- in_bit is ignored when in_en=0. No combinational path from in_* to out_*.

Decomposition:
- Shared package holds:
  - Default CNT_W and FIFO_DEPTH.
  - State encoding localparams ST_IDLE=1'b0, ST_RUN=1'b1.
  - Record width REC_W = CNT_W+1, with record packing {bit, len}.
- One sub-module: rle_fifo, a synchronous FWFT FIFO.
  - Parameters: width REC_W, depth FIFO_DEPTH.
  - Ports: push/pop/data/level/full/empty, plus the same clk/rst_n.
- The run-tracking FSM and overflow flag live in the top.

Test Plan:
- Normal runs: out_ready=1; in_en every cycle with bits 1,1,1,0,0; then flush -> records {1,3} then {0,2}; overflow=0; IDLE afterwards.
- Saturation: CNT_W=4 (MAXLEN=15); 17 consecutive 1s then flush -> {1,15} emitted on the 16th sample edge, then {1,2} on flush.
- Backpressure and overflow: out_ready=0; alternate 0/1 single-bit runs producing 6 emits -> fifo_level=4 and overflow=1 after the 5th emit; the 6th is also dropped. Then out_ready=1 -> exactly the first 4 records drain in order; overflow stays 1.
- Flush with in_en in the same cycle: run of 0 with len 3, then flush plus in_en with in_bit=1 -> {0,3} emitted; state stays RUN with len 1. A later flush alone -> {1,1}.
- Full plus simultaneous push/pop: fill to 4, then hold out_ready=1 while a run closes -> one pop and one push; level stays 4; overflow=0; order preserved.
- Asynchronous reset mid-run: rst_n low between edges during a 5-long run with 2 records queued -> out_valid, fifo_level and overflow read 0 before the next edge; no record from the partial run appears after release.
